// File: rtl/vga_sync_rx.sv
// vga_sync_rx: locks to an incoming VGA sync stream, checks line/frame lengths, recovers pixel coordinates
module vga_sync_rx #(
  parameter int H_DISP      = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_DISP      = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SYNC_POL    = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [2:0] rgb_in,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic [2:0] rgb_out,
  output logic       locked,
  output logic       line_err,
  output logic       frame_err
);
  localparam logic [10:0] H_TOTAL = 11'(H_DISP + H_FP + H_SYNC + H_BP);
  localparam logic [10:0] V_TOTAL = 11'(V_DISP + V_FP + V_SYNC + V_BP);
  localparam logic [9:0] H_ACT = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END = 10'(H_SYNC + H_BP + H_DISP);
  localparam logic [9:0] V_ACT = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END = 10'(V_SYNC + V_BP + V_DISP);
  localparam logic [9:0] CNT_MAX = '1;
  localparam logic POL = (SYNC_POL != 0);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
  state_t state, state_nxt;
  logic [GW-1:0] good, good_nxt;
  logic dirty, dirty_nxt;
  logic [9:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic h_prev, v_prev, h_armed;
  logic h_on, v_on, h_edge, v_edge, line_bad, frame_bad, mis, act, von;
  assign h_on = (hsync == POL);
  assign v_on = (vsync == POL);
  assign h_edge = p_tick && h_on && !h_prev;
  assign v_edge = h_edge && v_on && !v_prev;
  assign line_bad = h_edge && h_armed && (({1'b0, h_cnt} + 11'd1) != H_TOTAL);
  assign frame_bad = v_edge && (({1'b0, v_cnt} + 11'd1) != V_TOTAL);
  assign mis = line_bad || frame_bad;
  assign h_nxt = h_edge ? '0 : (h_cnt == CNT_MAX) ? h_cnt : h_cnt + 10'd1;
  assign v_nxt = v_edge ? '0 : (h_edge && v_cnt != CNT_MAX) ? v_cnt + 10'd1 : v_cnt;
  assign act = (h_nxt >= H_ACT) && (h_nxt < H_END) && (v_nxt >= V_ACT) && (v_nxt < V_END);
  assign von = act && (state_nxt == LOCKED);
  assign locked = (state == LOCKED);
  // Lock tracking: only sampling ticks can move the FSM, so a stalled p_tick freezes it
  always_comb begin
    state_nxt = state;
    good_nxt = good;
    dirty_nxt = dirty;
    if (p_tick) begin
      case (state)
        SEARCH: begin
          good_nxt = '0;
          dirty_nxt = 1'b0;
          state_nxt = v_edge ? VERIFY : SEARCH;
        end
        VERIFY: begin
          if (v_edge) begin
            dirty_nxt = 1'b0;
            good_nxt = (mis || dirty) ? '0 : good + GW'(1);
            if (!mis && !dirty && (good + GW'(1) == GW'(LOCK_FRAMES))) begin
              state_nxt = LOCKED;
              good_nxt = '0;
            end
          end else if (mis) begin
            good_nxt = '0;
            dirty_nxt = 1'b1;
          end
        end
        LOCKED: state_nxt = (mis || h_nxt == CNT_MAX) ? SEARCH : LOCKED;
        default: state_nxt = SEARCH;
      endcase
    end
  end
  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SEARCH;
      good <= '0;
      dirty <= 1'b0;
    end else begin
      state <= state_nxt;
      good <= good_nxt;
      dirty <= dirty_nxt;
    end
  end
  // Counters, edge history and registered pixel outputs, all advanced on sampling ticks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
      h_prev <= 1'b0;
      v_prev <= 1'b0;
      h_armed <= 1'b0;
      video_on <= 1'b0;
      rgb_out <= '0;
      pixel_x <= '0;
      pixel_y <= '0;
    end else if (p_tick) begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      h_prev <= h_on;
      if (h_edge) v_prev <= v_on;
      h_armed <= (state != SEARCH && state_nxt == SEARCH) ? 1'b0 : (h_armed || h_edge);
      video_on <= von;
      rgb_out <= von ? rgb_in : '0;
      if (von) begin
        pixel_x <= h_nxt - H_ACT;
        pixel_y <= v_nxt - V_ACT;
      end
    end
  end
  // Length-mismatch pulses; suppressed while searching since the timing is not yet trusted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_err <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      line_err <= line_bad && (state != SEARCH);
      frame_err <= frame_bad && (state != SEARCH);
    end
  end
endmodule
